// File: rtl/hr_window_ctrl_if.sv
// Control/status bundle between the heart-rate window scheduler, the external
// beat counter and the display/LED logic.
`timescale 1ns/1ps
interface hr_window_ctrl_if;
    logic        start;
    logic        stop;
    logic        continuous;
    logic [18:0] cnt_value;
    logic        cnt_clr;
    logic        cnt_en;
    logic        busy;
    logic [18:0] heartrate;
    logic        hr_valid;
    logic        sat;
    logic [3:0]  led_level;

    modport master (
        output start, stop, continuous, cnt_value,
        input  cnt_clr, cnt_en, busy, heartrate, hr_valid, sat, led_level
    );

    modport slave (
        input  start, stop, continuous, cnt_value,
        output cnt_clr, cnt_en, busy, heartrate, hr_valid, sat, led_level
    );
endinterface

// File: rtl/hr_window_ctrl.sv
// Gating-window scheduler: clears and enables the beat counter for a fixed window,
// then scales the captured count to BPM with saturation and a 4-LED thermometer.
`timescale 1ns/1ps
module hr_window_ctrl #(
    parameter int unsigned WINDOW_CYCLES = 750_000_000,
    parameter int unsigned SCALE         = 4,
    parameter int unsigned TH0           = 10,
    parameter int unsigned TH1           = 20,
    parameter int unsigned TH2           = 30,
    parameter int unsigned TH3           = 40
) (
    input  logic             clk,
    input  logic             rst,
    hr_window_ctrl_if.slave  bus
);
    localparam int unsigned       PW        = 19 + $clog2(SCALE + 1);
    localparam logic [31:0]       LAST_TICK = 32'(WINDOW_CYCLES - 1);
    localparam logic [PW-1:0]     HR_MAX    = PW'(19'h7FFFF);
    localparam logic [4*19-1:0]   TH_PACK   = {19'(TH3), 19'(TH2), 19'(TH1), 19'(TH0)};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        MEASURE = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [31:0]   timer_reg, timer_next;
    logic [18:0]   heartrate_reg, heartrate_next;
    logic          sat_reg, sat_next;
    logic [3:0]    led_reg, led_next;
    logic          hr_valid_reg;
    logic [PW-1:0] prod;

    // Full-width product so the saturation test sees every overflow bit.
    assign prod           = PW'(bus.cnt_value) * PW'(SCALE);
    assign sat_next       = (prod > HR_MAX);
    assign heartrate_next = sat_next ? 19'h7FFFF : prod[18:0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_led
            assign led_next[gi] = (heartrate_next > TH_PACK[gi*19 +: 19]);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        timer_next = '0;
        case (state_reg)
            IDLE: begin
                if (bus.start && !bus.stop) state_next = CLEAR;
            end
            CLEAR: begin
                state_next = bus.stop ? IDLE : MEASURE;
            end
            MEASURE: begin
                timer_next = timer_reg + 32'd1;
                if (bus.stop)                    state_next = IDLE;
                else if (timer_reg == LAST_TICK) state_next = CAPTURE;
            end
            CAPTURE: begin
                // A stop here still lets this capture land; it only blocks the restart.
                state_next = (bus.continuous && !bus.stop) ? CLEAR : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            heartrate_reg <= '0;
            sat_reg       <= 1'b0;
            led_reg       <= '0;
            hr_valid_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            hr_valid_reg <= (state_reg == CAPTURE);
            if (state_reg == CAPTURE) begin
                heartrate_reg <= heartrate_next;
                sat_reg       <= sat_next;
                led_reg       <= led_next;
            end
        end
    end

    assign bus.busy      = (state_reg != IDLE);
    assign bus.cnt_en    = (state_reg == MEASURE);
    assign bus.cnt_clr   = (state_reg == CLEAR);
    assign bus.heartrate = heartrate_reg;
    assign bus.hr_valid  = hr_valid_reg;
    assign bus.sat       = sat_reg;
    assign bus.led_level = led_reg;
endmodule

// File: tb/tb_hr_window_ctrl.sv
// Scenario bench for hr_window_ctrl: cycle-indexed stimulus vectors against
// window timing and BPM/threshold rules computed directly from beat counts.
`timescale 1ns/1ps
module tb_hr_window_ctrl;
    localparam int W  = 100;
    localparam int NC = 256;
    typedef logic [NC-1:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hr_window_ctrl_if bus ();

    hr_window_ctrl #(
        .WINDOW_CYCLES(W), .SCALE(4),
        .TH0(10), .TH1(20), .TH2(30), .TH3(40)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Behavioural 19-bit beat counter with one-cycle latency, plus a force path.
    logic        beat      = 1'b0;
    logic [18:0] cnt_q     = '0;
    logic        force_en  = 1'b0;
    logic [18:0] force_val = '0;
    always @(posedge clk) begin
        if (bus.cnt_clr)              cnt_q <= '0;
        else if (bus.cnt_en && beat)  cnt_q <= cnt_q + 19'd1;
    end
    assign bus.cnt_value = force_en ? force_val : cnt_q;

    int tests = 0;
    int fails = 0;
    int last_hr = 0;

    vec_t        en_obs, clr_obs, busy_obs, val_obs;
    logic [18:0] hr_obs  [NC];
    logic [3:0]  led_obs [NC];
    logic        sat_obs [NC];

    function automatic vec_t span(input int lo, input int hi);
        vec_t v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic vec_t rand_beats(input int n, input int lo, input int hi);
        vec_t v = '0;
        while ($countones(v) < n) v[$urandom_range(hi, lo)] = 1'b1;
        return v;
    endfunction

    function automatic int bpm(input int beats);
        int p = beats * 4;
        return (p > 524287) ? 524287 : p;
    endfunction

    function automatic logic [3:0] level(input int hr);
        return {hr > 40, hr > 30, hr > 20, hr > 10};
    endfunction

    // Cycle c is the cycle ending at edge c; inputs for it are driven 1 ns after edge c-1.
    task automatic play(input vec_t start_v, stop_v, beat_v, cont_v, rst_v, input int ncyc);
        en_obs = '0; clr_obs = '0; busy_obs = '0; val_obs = '0;
        for (int c = 0; c < ncyc; c++) begin
            bus.start      = start_v[c];
            bus.stop       = stop_v[c];
            bus.continuous = cont_v[c];
            beat           = beat_v[c];
            rst            = rst_v[c];
            en_obs[c]   = bus.cnt_en;
            clr_obs[c]  = bus.cnt_clr;
            busy_obs[c] = bus.busy;
            val_obs[c]  = bus.hr_valid;
            hr_obs[c]   = bus.heartrate;
            led_obs[c]  = bus.led_level;
            sat_obs[c]  = bus.sat;
            @(posedge clk); #1;
        end
        bus.start = 1'b0; bus.stop = 1'b0; bus.continuous = 1'b0; beat = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b1; bus.stop = 1'b0; bus.continuous = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++;
            if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        end
        tests++;
        if (bus.heartrate !== 19'd0) begin fails++; $display("FAIL reset_hr: got %0d expected 0", bus.heartrate); end
        tests++;
        if ({bus.led_level, bus.sat, bus.hr_valid, bus.cnt_en, bus.cnt_clr} !== 8'h00) begin
            fails++;
            $display("FAIL reset_flags: got led=%b sat=%b val=%b en=%b clr=%b expected all 0",
                     bus.led_level, bus.sat, bus.hr_valid, bus.cnt_en, bus.cnt_clr);
        end
        rst = 1'b0; bus.start = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_start_ignored: busy got %b expected 0", bus.busy); end
    endtask

    task automatic test_single_shot();
        vec_t b = rand_beats(12, 2, W + 1) | span(0, 1) | span(W + 2, W + 3);
        play(span(0, 0), '0, b, '0, '0, 110);
        tests++;
        if (en_obs !== span(2, W + 1)) begin fails++; $display("FAIL single_en: got %h expected %h", en_obs, span(2, W + 1)); end
        tests++;
        if (clr_obs !== span(1, 1)) begin fails++; $display("FAIL single_clr: got %h expected %h", clr_obs, span(1, 1)); end
        tests++;
        if (busy_obs !== span(1, W + 2)) begin fails++; $display("FAIL single_busy: got %h expected %h", busy_obs, span(1, W + 2)); end
        tests++;
        if (val_obs !== span(W + 3, W + 3)) begin fails++; $display("FAIL single_valid: got %h expected %h", val_obs, span(W + 3, W + 3)); end
        tests++;
        if (hr_obs[W + 3] !== 19'(bpm(12))) begin fails++; $display("FAIL single_hr: got %0d expected %0d", hr_obs[W + 3], bpm(12)); end
        tests++;
        if (led_obs[W + 3] !== level(bpm(12)) || sat_obs[W + 3] !== 1'b0) begin
            fails++;
            $display("FAIL single_led_sat: got led=%b sat=%b expected led=%b sat=0", led_obs[W + 3], sat_obs[W + 3], level(bpm(12)));
        end
        last_hr = bpm(12);
    endtask

    task automatic test_abort();
        int   n2 = int'($urandom_range(30, 1));
        vec_t b  = rand_beats(20, 2, 50) | rand_beats(5, 51, 61) | rand_beats(n2, 62, 161);
        play(span(0, 0) | span(60, 60), span(50, 50), b, '0, '0, 170);
        tests++;
        if (en_obs !== (span(2, 50) | span(62, 161))) begin fails++; $display("FAIL abort_en: got %h expected %h", en_obs, span(2, 50) | span(62, 161)); end
        tests++;
        if (busy_obs !== (span(1, 50) | span(61, 162))) begin fails++; $display("FAIL abort_busy: got %h expected %h", busy_obs, span(1, 50) | span(61, 162)); end
        tests++;
        if (val_obs !== span(163, 163)) begin fails++; $display("FAIL abort_valid: got %h expected %h", val_obs, span(163, 163)); end
        tests++;
        if (hr_obs[60] !== 19'(last_hr)) begin fails++; $display("FAIL abort_hr_held: got %0d expected %0d", hr_obs[60], last_hr); end
        tests++;
        if (hr_obs[163] !== 19'(bpm(n2))) begin fails++; $display("FAIL abort_restart_hr: got %0d expected %0d", hr_obs[163], bpm(n2)); end
        last_hr = bpm(n2);
    endtask

    task automatic test_continuous();
        vec_t b = rand_beats(5, 2, W + 1) | span(W + 2, W + 3) | rand_beats(8, W + 4, 2 * W + 3);
        play(span(0, 0), '0, b, span(0, 150), '0, 215);
        tests++;
        if (val_obs !== (span(103, 103) | span(205, 205))) begin fails++; $display("FAIL cont_valid: got %h expected %h", val_obs, span(103, 103) | span(205, 205)); end
        tests++;
        if (clr_obs !== (span(1, 1) | span(103, 103))) begin fails++; $display("FAIL cont_clr: got %h expected %h", clr_obs, span(1, 1) | span(103, 103)); end
        tests++;
        if (en_obs !== (span(2, 101) | span(104, 203))) begin fails++; $display("FAIL cont_en: got %h expected %h", en_obs, span(2, 101) | span(104, 203)); end
        tests++;
        if (busy_obs !== span(1, 204)) begin fails++; $display("FAIL cont_busy: got %h expected %h", busy_obs, span(1, 204)); end
        tests++;
        if (hr_obs[103] !== 19'(bpm(5)) || led_obs[103] !== level(bpm(5))) begin
            fails++; $display("FAIL cont_first: got hr=%0d led=%b expected hr=%0d led=%b", hr_obs[103], led_obs[103], bpm(5), level(bpm(5)));
        end
        tests++;
        if (hr_obs[205] !== 19'(bpm(8)) || led_obs[205] !== level(bpm(8))) begin
            fails++; $display("FAIL cont_second: got hr=%0d led=%b expected hr=%0d led=%b", hr_obs[205], led_obs[205], bpm(8), level(bpm(8)));
        end
        last_hr = bpm(8);
    endtask

    task automatic test_saturation();
        force_en = 1'b1; force_val = 19'd200000;
        play(span(0, 0), span(102, 102), '0, span(0, 105), '0, 106);
        tests++;
        if (val_obs !== span(103, 103)) begin fails++; $display("FAIL sat_valid: got %h expected %h", val_obs, span(103, 103)); end
        tests++;
        if (busy_obs !== span(1, 102) || clr_obs !== span(1, 1)) begin
            fails++; $display("FAIL sat_stop_at_capture: busy %h clr %h expected busy %h clr %h", busy_obs, clr_obs, span(1, 102), span(1, 1));
        end
        tests++;
        if (hr_obs[103] !== 19'(bpm(200000)) || sat_obs[103] !== 1'b1 || led_obs[103] !== level(bpm(200000))) begin
            fails++; $display("FAIL sat_value: got hr=%0d sat=%b led=%b expected hr=%0d sat=1 led=%b",
                              hr_obs[103], sat_obs[103], led_obs[103], bpm(200000), level(bpm(200000)));
        end
    endtask

    task automatic test_random_scale();
        int vals [6];
        vals[0] = 131071;
        vals[1] = 131072;
        vals[2] = int'($urandom_range(12, 0));
        vals[3] = int'($urandom_range(3, 0));
        vals[4] = int'($urandom_range(9, 4));
        vals[5] = int'($urandom_range(524287, 0));
        force_en = 1'b1;
        foreach (vals[i]) begin
            force_val = 19'(vals[i]);
            play(span(0, 0), '0, '0, '0, '0, 105);
            tests++;
            if (hr_obs[103] !== 19'(bpm(vals[i])) || sat_obs[103] !== (vals[i] * 4 > 524287) || led_obs[103] !== level(bpm(vals[i]))) begin
                fails++; $display("FAIL scale_%0d: cnt=%0d got hr=%0d sat=%b led=%b expected hr=%0d sat=%b led=%b",
                                  i, vals[i], hr_obs[103], sat_obs[103], led_obs[103],
                                  bpm(vals[i]), (vals[i] * 4 > 524287), level(bpm(vals[i])));
            end
        end
        force_en = 1'b0;
        last_hr = bpm(vals[5]);
    endtask

    task automatic test_midwindow();
        int   k = int'($urandom_range(20, 3));
        vec_t s = span(0, 0) | span(10, 10) | span(20, 20) | span(50, 50) | span(101, 102);
        play(s, '0, rand_beats(k, 2, W + 1), '0, '0, 110);
        tests++;
        if (en_obs !== span(2, W + 1) || val_obs !== span(W + 3, W + 3)) begin
            fails++; $display("FAIL mid_ignored_start: en %h valid %h expected en %h valid %h", en_obs, val_obs, span(2, W + 1), span(W + 3, W + 3));
        end
        tests++;
        if (hr_obs[W + 3] !== 19'(bpm(k))) begin fails++; $display("FAIL mid_hr: got %0d expected %0d", hr_obs[W + 3], bpm(k)); end
        play(span(0, 0), '0, rand_beats(4, 2, 29), '0, span(30, 30), 40);
        tests++;
        if (en_obs !== span(2, 30) || busy_obs !== span(1, 30) || val_obs !== '0) begin
            fails++; $display("FAIL mid_reset_ctrl: en %h busy %h valid %h expected en %h busy %h valid 0",
                              en_obs, busy_obs, val_obs, span(2, 30), span(1, 30));
        end
        tests++;
        if (hr_obs[29] !== 19'(bpm(k)) || hr_obs[31] !== 19'd0 || led_obs[31] !== 4'd0 || sat_obs[31] !== 1'b0) begin
            fails++; $display("FAIL mid_reset_outputs: hr before %0d after %0d led %b sat %b expected before %0d after 0 led 0000 sat 0",
                              hr_obs[29], hr_obs[31], led_obs[31], sat_obs[31], bpm(k));
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.continuous = 1'b0;
        test_reset();
        test_single_shot();
        test_abort();
        test_continuous();
        test_saturation();
        test_random_scale();
        test_midwindow();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hr_window_ctrl.md
# hr_window_ctrl

Measurement-window scheduler for the heartbeat beat-counter datapath on the Smart-Bike board. It clears and enables the external beat counter for a fixed gating window, samples the count at window end, and scales it to beats per minute. It publishes the `heartrate` value and a 4-LED thermometer level for the onboard LEDs. It sits between the button/sensor front end (which drives the counter) and the display/LED logic, and runs in single-shot or continuous mode.

## Interface
Parameters:
- `WINDOW_CYCLES`, default 750_000_000: gating window length in `clk` cycles (15 s at 50 MHz); legal range 2 .. 2^32-1.
- `SCALE`, default 4: multiplier from beats-per-window to BPM (60 s / 15 s).
- `TH0`, `TH1`, `TH2`, `TH3`, defaults 10, 20, 30, 40: LED level thresholds, compared with strict greater-than.

Ports:
- `clk`  in  1  — 50 MHz system clock. Single clock domain.
- `rst`  in  1  — reset, synchronous, active-high.
- `start`  in  1  — request one measurement. Sampled only in IDLE.
- `stop`  in  1  — abort the current measurement or continuous run.
- `continuous`  in  1  — when 1, a new window starts automatically after each capture.
- `cnt_value`  in  19  — registered beat count from the external counter.
- `cnt_clr`  out  1  — one-cycle synchronous clear to the counter.
- `cnt_en`  out  1  — counter count-enable (gating window).
- `busy`  out  1  — high when state ≠ IDLE.
- `heartrate`  out  19  — last captured BPM.
- `hr_valid`  out  1  — one-cycle pulse when `heartrate` updates.
- `sat`  out  1  — last capture saturated.
- `led_level`  out  4  — thermometer code: bit i = (`heartrate` > THi).

## Operation
- FSM states: IDLE, CLEAR, MEASURE, CAPTURE. A 32-bit window timer runs inside MEASURE.
- IDLE:
  - `cnt_en` = 0, `cnt_clr` = 0.
  - `start` = 1 and `stop` = 0 → CLEAR.
- CLEAR: lasts 1 cycle.
  - `cnt_clr` = 1, timer ← 0.
  - `stop` → IDLE; otherwise → MEASURE.
- MEASURE:
  - `cnt_en` = 1, timer increments each cycle.
  - timer == WINDOW_CYCLES-1 → CAPTURE.
  - `stop` → IDLE with no capture. `heartrate`, `sat`, `led_level` keep their previous values.
- CAPTURE: lasts 1 cycle.
  - `cnt_en` = 0.
  - prod = `cnt_value` × SCALE, computed at full width (19 + clog2(SCALE+1) bits).
  - `heartrate` ← min(prod, 524287); `sat` ← (prod > 524287).
  - `led_level` ← thresholds of the new value, registered in the same edge as `heartrate`.
  - `hr_valid` ← 1 for one cycle.
  - Next state: `continuous` = 1 and `stop` = 0 → CLEAR; otherwise → IDLE. A `stop` here does not cancel the capture.
- `start` outside IDLE is ignored. `stop` has priority over `start` and over `continuous`.
- Changes to `continuous` take effect only at the next CAPTURE decision.
- `rst` in any state, including mid-window:
  - next cycle: state IDLE, timer 0.
  - all outputs 0 (`heartrate` 0, `led_level` 0000, `sat` 0).
  - no `hr_valid` pulse.

## Timing
- All outputs are registered; `busy`, `cnt_en`, and `cnt_clr` are decoded from the state register only.
- With `start` sampled at edge 0:
  - CLEAR during cycle 1.
  - `cnt_en` high for exactly WINDOW_CYCLES cycles (cycles 2 .. WINDOW_CYCLES+1).
  - CAPTURE at cycle WINDOW_CYCLES+2.
  - `heartrate` and `hr_valid` visible at cycle WINDOW_CYCLES+3.
- The counter has 1-cycle latency. CAPTURE samples `cnt_value` one cycle after `cnt_en` falls, so a beat in the last enabled cycle is included.
- Continuous-mode period: WINDOW_CYCLES + 2 cycles per result. `cnt_clr` pulses in the cycle immediately after CAPTURE.
- `stop` asserted in cycle k of MEASURE: `cnt_en` is low from cycle k+1, and `busy` is low from cycle k+1.

## Test plan
Bench uses WINDOW_CYCLES = 100 and SCALE = 4, with a behavioural 19-bit counter.
- Reset: hold `rst` 3 cycles → all outputs 0, `busy` = 0; `start` during `rst` is ignored.
- Single shot: `start` at cycle 0, 12 beats during the window → `cnt_en` high cycles 2..101; `heartrate` = 48, `led_level` = 1111, `sat` = 0; `hr_valid` single pulse at cycle 103, `busy` low at 103.
- Continuous: windows of 5 then 8 beats → `heartrate` 20 (`led_level` 0001), then 32 (`led_level` 0111); `hr_valid` pulses 102 cycles apart; `cnt_clr` pulses between windows.
- Abort: `stop` at MEASURE cycle 50 after a prior result of 48 → `cnt_en` low next cycle, no `hr_valid`, `heartrate` stays 48; `start` at cycle 60 is accepted.
- Saturation: `cnt_value` = 200000 at capture → `heartrate` = 524287, `sat` = 1, `led_level` = 1111.
- Mid-window reset and ignored start: `start` repeated during MEASURE has no effect on the window length; `rst` at MEASURE cycle 30 → next cycle `busy` = 0, `cnt_en` = 0, `heartrate` = 0.
